// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, parity modes and
// the bit-clock divider calculation reused by the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } uart_rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int div_calc(input int freq, input int baud, input int os);
    return freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-clk tick every DIV clocks, held at zero
// while clear is high so the first tick lands DIV clocks after release.
module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting, runtime parity,
// 1/2 stop bits, error/break reporting and a one-entry valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int FREQUENCY  = 10000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_serial,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int DIV = div_calc(FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [OW-1:0] SAMP0    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] SAMP1    = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] SAMP2    = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_rx_state_t       state;
  logic                 sync_p0, s;
  logic                 armed;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 samp0, samp1, bit_val;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           par_mode_r;
  logic                 par_bit, par_err_r, frame_err_r, stop_cnt;
  logic                 tick, mid, bit_end, live_maj, par_en;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .tick    (tick)
  );

  // Third vote uses the live sample so STOP can exit on the mid-sample tick.
  assign live_maj = maj3(samp0, samp1, s);
  assign mid      = tick && (os_cnt == SAMP2);
  assign bit_end  = tick && (os_cnt == OS_LAST);
  assign par_en   = (par_mode_r == PAR_EVEN) || (par_mode_r == PAR_ODD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0       <= 1'b1;
      s             <= 1'b1;
      state         <= ST_IDLE;
      armed         <= 1'b0;
      os_cnt        <= '0;
      bit_idx       <= '0;
      samp0         <= 1'b1;
      samp1         <= 1'b1;
      bit_val       <= 1'b1;
      shreg         <= '0;
      par_mode_r    <= PAR_NONE;
      par_bit       <= 1'b0;
      par_err_r     <= 1'b0;
      frame_err_r   <= 1'b0;
      stop_cnt      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      sync_p0    <= rx_serial;
      s          <= sync_p0;
      rx_overrun <= 1'b0;
      if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
        if (os_cnt == SAMP0) samp0 <= s;
        if (os_cnt == SAMP1) samp1 <= s;
        if (os_cnt == SAMP2) bit_val <= live_maj;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          os_cnt   <= '0;
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
          // A line stuck low must go high once before another frame is armed.
          if (s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed       <= 1'b0;
            par_mode_r  <= parity_mode;
            par_bit     <= 1'b0;
            par_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
            state       <= ST_START;
          end
        end
        ST_START: if (bit_end) state <= bit_val ? ST_IDLE : ST_DATA;
        ST_DATA: if (bit_end) begin
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) state <= par_en ? ST_PARITY : ST_STOP;
          else bit_idx <= bit_idx + BW'(1);
        end
        ST_PARITY: if (bit_end) begin
          par_bit   <= bit_val;
          par_err_r <= ((^shreg) ^ bit_val) != (par_mode_r == PAR_ODD);
          state     <= ST_STOP;
        end
        ST_STOP: if (mid) begin
          if (!live_maj) frame_err_r <= 1'b1;
          if (STOP_BITS == 1 || stop_cnt) state <= ST_DONE;
          else stop_cnt <= 1'b1;
        end
        ST_DONE: begin
          if (!rx_valid || rx_ready) begin
            rx_data       <= shreg;
            rx_parity_err <= par_err_r;
            rx_frame_err  <= frame_err_r;
            rx_break      <= (shreg == '0) && !(par_en && par_bit) && frame_err_r;
            rx_valid      <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: table of frames plus hand-written
// sequences for glitches, break, overrun, two stop bits and mid-frame reset.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic [1:0] pmode0 = 2'b00, pmode1 = 2'b00;
  logic       ready0 = 1'b0, ready1 = 1'b0;
  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, brk0, brk1, ovr0, ovr1;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.FREQUENCY(18432000), .BAUD_RATE(115200), .OVERSAMPLE(16),
                  .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .rx_serial(line0), .parity_mode(pmode0),
    .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_break(brk0), .rx_overrun(ovr0));

  uart_rx_param #(.FREQUENCY(18432000), .BAUD_RATE(115200), .OVERSAMPLE(16),
                  .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .rx_serial(line1), .parity_mode(pmode1),
    .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_break(brk1), .rx_overrun(ovr1));

  always @(negedge clk) if (ovr0) ovr_cnt <= ovr_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       pbit;
    logic       stop_ok;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int tgt, input logic v);
    if (tgt == 0) line0 = v;
    else line1 = v;
  endtask

  task automatic send_frame(input int tgt, input logic [7:0] d, input logic pen,
                            input logic pb, input int nstop, input logic st1,
                            input logic st2, input int glitch_bit);
    drive(tgt, 1'b0); hold(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(tgt, d[i]);
      if (i == glitch_bit) begin
        hold(BIT / 2); drive(tgt, ~d[i]); hold(1); drive(tgt, d[i]); hold(BIT / 2 - 1);
      end else begin
        hold(BIT);
      end
    end
    if (pen) begin drive(tgt, pb); hold(BIT); end
    drive(tgt, st1); hold(BIT);
    if (nstop == 2) begin drive(tgt, st2); hold(BIT); end
    drive(tgt, 1'b1);
  endtask

  task automatic wait_valid(input int tgt, input int budget);
    int k = 0;
    while (k < budget && ((tgt == 0) ? !valid0 : !valid1)) begin
      @(negedge clk);
      k++;
    end
    check("valid_timeout", (tgt == 0) ? int'(valid0) : int'(valid1), 1);
  endtask

  task automatic accept(input int tgt);
    if (tgt == 0) ready0 = 1'b1; else ready1 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0; ready1 = 1'b0;
    check("accept_clears", (tgt == 0) ? int'(valid0) : int'(valid1), 0);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  seen;
    logic pen;

    vecs[0] = '{8'hA5, PAR_NONE, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h07, PAR_EVEN, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h07, PAR_EVEN, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h07, PAR_ODD,  1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h00, PAR_NONE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h3C, PAR_ODD,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, PAR_EVEN, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    hold(5);
    check("rst_valid", valid0, 0);
    check("rst_data", data0, 0);
    check("rst_perr", perr0, 0);
    check("rst_ferr", ferr0, 0);
    check("rst_brk", brk0, 0);
    check("rst_ovr", ovr0, 0);
    reset_n = 1'b1;
    hold(20);

    for (int i = 0; i < 7; i++) begin
      pmode0 = vecs[i].pmode;
      pen = (vecs[i].pmode == PAR_EVEN) || (vecs[i].pmode == PAR_ODD);
      send_frame(0, vecs[i].data, pen, vecs[i].pbit, 1, vecs[i].stop_ok, 1'b1, -1);
      wait_valid(0, 400);
      check("vec_data", data0, vecs[i].exp_data);
      check("vec_perr", perr0, vecs[i].exp_perr);
      check("vec_ferr", ferr0, vecs[i].exp_ferr);
      check("vec_brk", brk0, vecs[i].exp_brk);
      accept(0);
      hold(40);
    end
    pmode0 = PAR_NONE;

    base = ovr_cnt;
    line0 = 1'b0; hold(50); line0 = 1'b1; hold(400);
    check("pulse_no_valid", valid0, 0);
    check("pulse_idle", int'(dut.state), int'(ST_IDLE));

    send_frame(0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3);
    wait_valid(0, 400);
    check("glitch_data", data0, 8'h00);
    check("glitch_ferr", ferr0, 0);
    accept(0);
    hold(40);

    line0 = 1'b0; hold(12 * BIT);
    check("break_valid", valid0, 1);
    check("break_flag", brk0, 1);
    check("break_data", data0, 0);
    check("break_ferr", ferr0, 1);
    check("break_no_ovr", ovr_cnt - base, 0);
    line0 = 1'b1; hold(5);
    accept(0);
    hold(400);
    check("break_single_word", valid0, 0);

    base = ovr_cnt;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    hold(40);
    check("ovr_held_data", data0, 8'h11);
    check("ovr_pulse_count", ovr_cnt - base, 1);
    accept(0);
    hold(40);

    base = ovr_cnt;
    seen = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    fork
      send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
      for (int k = 0; k < 3000 && !seen; k++) begin
        @(negedge clk);
        if (dut.state == ST_DONE) begin
          ready0 = 1'b1; seen = 1'b1;
          @(negedge clk);
          ready0 = 1'b0;
        end
      end
    join
    hold(40);
    check("swap_done_seen", seen, 1);
    check("swap_valid", valid0, 1);
    check("swap_data", data0, 8'h22);
    check("swap_no_ovr", ovr_cnt - base, 0);
    accept(0);
    hold(40);

    send_frame(1, 8'h5A, 1'b0, 1'b0, 2, 1'b1, 1'b0, -1);
    wait_valid(1, 400);
    check("stop2_data", data1, 8'h5A);
    check("stop2_ferr", ferr1, 1);
    check("stop2_brk", brk1, 0);
    accept(1);
    hold(40);
    send_frame(1, 8'hC3, 1'b0, 1'b0, 2, 1'b1, 1'b1, -1);
    wait_valid(1, 400);
    check("stop2_ok_data", data1, 8'hC3);
    check("stop2_ok_ferr", ferr1, 0);
    accept(1);
    hold(40);

    send_frame(0, 8'h66, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    wait_valid(0, 400);
    check("pre_rst_data", data0, 8'h66);
    fork
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
      begin
        hold(5 * BIT + BIT / 2);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", valid0, 0);
        check("midrst_data", data0, 0);
        check("midrst_perr", perr0, 0);
        check("midrst_ferr", ferr0, 0);
        check("midrst_brk", brk0, 0);
        check("midrst_ovr", ovr0, 0);
      end
    join
    hold(20);
    reset_n = 1'b1;
    hold(20);
    check("post_rst_idle_valid", valid0, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1, -1);
    wait_valid(0, 400);
    check("post_rst_data", data0, 8'h3C);
    check("post_rst_ferr", ferr0, 0);
    accept(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, next generation of the single-format 8N1 receiver. Supports configurable data width, runtime-selectable parity, one or two stop bits, and 3-sample majority voting on an oversampled bit clock. Reports parity, framing, break and overrun conditions. Delivers bytes through a valid/ready handshake with a one-entry holding register, and sits between the pad synchroniser-free `rx_serial` pin and the downstream command/FIFO logic.

## Interface
- `FREQUENCY`, 10000000: input clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bits/s.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥8.
- `DATA_BITS`, 8: data width, 5..9.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` in 1: single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_serial` in 1: asynchronous serial line; idles high.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none. Captured at start-bit detection.
- `rx_data` out DATA_BITS: received word, LSB first on the line.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts `rx_data` when `rx_valid && rx_ready`.
- `rx_parity_err` out 1: parity mismatch for the held word.
- `rx_frame_err` out 1: a stop bit sampled low for the held word.
- `rx_break` out 1: all data bits 0, parity 0 if enabled, and stop bit 0, for the held word.
- `rx_overrun` out 1: one-cycle pulse when a completed frame is dropped.

## Operation
- `rx_serial` passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised bit `s`.
- Tick generator: `DIV = FREQUENCY/(BAUD_RATE*OVERSAMPLE)`. The counter runs 0..DIV-1 and emits a one-clk tick at DIV-1. It is held at 0 in IDLE and restarts on start detection.
- Per bit, a tick counter runs 0..OVERSAMPLE-1. Samples are taken at ticks OS/2-1, OS/2 and OS/2+1. The bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: when `s`==0, latch `parity_mode` and go to START.
  - START: at bit end, majority 0 goes to DATA; majority 1 is a glitch and returns to IDLE with no outputs.
  - DATA: shift majority bits into bit index 0..DATA_BITS-1. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: capture the majority bit. Error if XOR(data, parity bit) is not 0 for even mode, or not 1 for odd mode.
  - STOP: sample the majority STOP_BITS times. Any 0 sets the frame error. Leave STOP at the mid-sample tick (OS/2+1) of the last stop bit, not at bit end, so back-to-back frames are not lost.
  - DONE: one clk. Load the holding register, or drop the frame, then go to IDLE.
- Holding register behaviour in DONE:
  - If `rx_valid`==0, or `rx_valid && rx_ready` in the same clk, load `rx_data` and the error flags and set `rx_valid`.
  - Otherwise keep the old word and pulse `rx_overrun`.
- `rx_valid` clears on handshake when no load happens in that clk.
- Flags are word-qualified. They are valid only with `rx_valid` and change only on load.

## Timing
- On `reset_n` low, immediately:
  - All outputs are 0, except `rx_data`=0.
  - FSM goes to IDLE and counters clear.
  - The synchroniser resets to 1.
  - An in-flight frame is discarded.
- Start detection occurs 2 clks after the falling edge on the pin (synchroniser delay).
- `rx_valid` rises on the clk after DONE. That is 2 clks after the last stop-bit mid-sample tick.
- Handshake:
  - Acceptance happens on any clk with `rx_valid && rx_ready`.
  - `rx_ready` may be high while `rx_valid` is low; this has no effect.
  - There is no combinational path from `rx_ready` to `rx_valid`.
- Simultaneous load and accept produces no overrun; the new word replaces the old.
- A line held low forever gives one break word, then no further frames until `s` returns to 1 (IDLE requires `s` high for one tick before re-arming).
- Counter widths are `$clog2(DIV)` and `$clog2(OVERSAMPLE)`. The bit index is `$clog2(DATA_BITS)`. No wrap-around beyond the terminal value.

## Structure
- Package `uart_pkg`:
  - State enum `uart_rx_state_t`.
  - `parity_mode` encodings `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - `function div_calc(freq, baud, os)`.
- Sub-module `uart_tick_gen` (parameters DIV; ports `clk`, `reset_n`, `clear`, `tick`). It is reusable by the future transmitter.
- Everything else lives in `uart_rx_param`.

## Test plan
- FREQUENCY=18432000, BAUD_RATE=115200, OS=16 (DIV=10), 8N1, send 0xA5 → `rx_valid` with `rx_data`=0xA5 and all flags 0; accept clears `rx_valid`.
- Even parity with 0x07 and parity bit 1 → 0x07 with no error. Same frame with parity bit 0 → `rx_parity_err`=1. Odd mode with bit 0 → no error.
- 50-clk low pulse on an idle line → no `rx_valid`, FSM back to IDLE. Single-clk 1 glitch at the mid-bit sample of data bit 3 of 0x00 → word 0x00 (majority rejects it).
- STOP_BITS=2, second stop bit low → `rx_frame_err`=1. Line low for 12 bit times → `rx_break`=1 and `rx_data`=0, and only one word is delivered.
- `rx_ready`=0, send 0x11 then 0x22 back-to-back → 0x11 held and one `rx_overrun` pulse. With `rx_ready`=1 during DONE of 0x22 → 0x22 loaded and no overrun.
- Assert `reset_n` low mid data bit 4 of 0x5A → all outputs are 0 immediately. After release, send 0x3C → 0x3C is received correctly.
